mem_access: RTL and testbench

Memory-access pipeline stage between execute and writeback. Takes one issued instruction per cycle from execute. Performs at most one data-memory load or store through a valid/ready request and response interface, stalling upstream while the access is in flight. Hands the instruction and its result data to writeback, and drops in-flight work when writeback flushes.

---
 rtl/mem_access.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: one load/store per instruction over a valid/ready dmem port, stalls execute meanwhile.
// Optional `MEM_MISALIGN_EXCEPT_EN: misaligned H/W accesses trap instead of being issued at the aligned address.
package mem_access_pkg;
  typedef logic [31:0] reg_data_t;

  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;
  typedef enum logic [3:0] {
    EXCEPT_NONE           = 4'd0,
    EXCEPT_MISALIGN_LOAD  = 4'd4,
    EXCEPT_MISALIGN_STORE = 4'd6
  } except_code_e;

  typedef struct packed {
    logic         valid;
    except_code_e code;
  } except_t;

  typedef struct packed {
    mem_op_e   mem_op;
    mem_size_e mem_size;
    logic      mem_signed;
  } decode_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    decode_t     decode;
    except_t     except;
  } issued_instr_t;

  typedef struct packed {
    logic [1:0] priv;
    logic       irq_en;
  } program_state_t;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  program_state_t        i_ps,
  input  issued_instr_t         i_instr,
  input  reg_data_t             i_data,
  input  reg_data_t             i_store_data,
  input  logic                  i_flush,
  output logic                  o_stall,
  output issued_instr_t         o_instr,
  output reg_data_t             o_data,
  output logic                  o_dmem_req_valid,
  input  logic                  i_dmem_req_ready,
  output logic                  o_dmem_we,
  output logic [ADDR_W-1:0]     o_dmem_addr,
  output logic [DATA_W-1:0]     o_dmem_wdata,
  output logic [DATA_W/8-1:0]   o_dmem_wstrb,
  input  logic                  i_dmem_resp_valid,
  input  logic [DATA_W-1:0]     i_dmem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  issued_instr_t     instr_q, instr_d;
  issued_instr_t     out_instr_q, out_instr_d;
  reg_data_t         addr_q, addr_d;
  reg_data_t         out_data_q, out_data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic              is_mem;
  logic              trap;
  logic [1:0]        st_lane;
  logic [1:0]        ld_lane;
  logic [DATA_W-1:0] st_wdata;
  logic [STRB_W-1:0] st_wstrb;
  logic [DATA_W-1:0] ld_shift;
  reg_data_t         ld_data;

  // Program state is carried alongside the pipe elsewhere; nothing here consumes it.
  logic unused_ps;
  assign unused_ps = ^i_ps;

  // Misaligned low address bits are dropped: H keeps only bit 1, W keeps none.
  function automatic logic [1:0] eff_lane(input mem_size_e sz, input logic [1:0] a);
    case (sz)
      MEM_B:   return a;
      MEM_H:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  assign is_mem = i_instr.valid &&
                  (i_instr.decode.mem_op == MEM_LOAD || i_instr.decode.mem_op == MEM_STORE);

`ifdef MEM_MISALIGN_EXCEPT_EN
  logic misaligned;
  assign misaligned = (i_instr.decode.mem_size == MEM_H && i_data[0]) ||
                      (i_instr.decode.mem_size == MEM_W && i_data[1:0] != 2'b00);
  assign trap = is_mem && misaligned;
`else
  assign trap = 1'b0;
`endif

  // Store lane formatting, computed from the incoming instruction at capture time.
  assign st_lane = eff_lane(i_instr.decode.mem_size, i_data[1:0]);

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    st_wdata = i_store_data[DATA_W-1:0];
    st_wstrb = '1;
    case (i_instr.decode.mem_size)
      MEM_B: begin
        st_wdata = {(DATA_W/8){i_store_data[7:0]}};
        st_wstrb = STRB_W'(1) << st_lane;
      end
      MEM_H: begin
        st_wdata = {(DATA_W/16){i_store_data[15:0]}};
        st_wstrb = STRB_W'(3) << st_lane;
      end
      default: ;
    endcase
  end

  // Load lane extraction from the captured size/sign and address.
  assign ld_lane  = eff_lane(instr_q.decode.mem_size, addr_q[1:0]);
  assign ld_shift = i_dmem_rdata >> {ld_lane, 3'b000};

  always_comb begin
    ld_data = i_dmem_rdata;
    case (instr_q.decode.mem_size)
      MEM_B: ld_data = instr_q.decode.mem_signed ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                                 : {24'b0, ld_shift[7:0]};
      MEM_H: ld_data = instr_q.decode.mem_signed ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                                 : {16'b0, ld_shift[15:0]};
      default: ;
    endcase
  end

  // NOTE: synchronous reset sampled on the clock edge; all sequential state uses non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    out_instr_d = '0;
    out_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (!i_flush) begin
          if (trap) begin
            out_instr_d              = i_instr;
            out_instr_d.except.valid = 1'b1;
            out_instr_d.except.code  = (i_instr.decode.mem_op == MEM_LOAD) ?
                                       EXCEPT_MISALIGN_LOAD : EXCEPT_MISALIGN_STORE;
            out_data_d               = i_data;
          end else if (is_mem) begin
            instr_d = i_instr;
            addr_d  = i_data;
            wdata_d = st_wdata;
            wstrb_d = (i_instr.decode.mem_op == MEM_STORE) ? st_wstrb : '0;
            state_d = S_REQ;
          end else begin
            out_instr_d = i_instr;
            out_data_d  = i_data;
          end
        end
      end
      S_REQ: begin
        if (i_dmem_req_ready) begin
          if (instr_q.decode.mem_op == MEM_LOAD) begin
            state_d = i_flush ? S_DRAIN : S_WAIT;
          end else begin
            // The store has left even when flushed; only its writeback is suppressed.
            state_d = S_IDLE;
            if (!i_flush) begin
              out_instr_d = instr_q;
              out_data_d  = addr_q;
            end
          end
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          state_d = i_dmem_resp_valid ? S_IDLE : S_DRAIN;
        end else if (i_dmem_resp_valid) begin
          state_d     = S_IDLE;
          out_instr_d = instr_q;
          out_data_d  = ld_data;
        end
      end
      S_DRAIN: begin
        // A flush here has nothing left to kill; the orphaned response still retires the drain.
        if (i_dmem_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      out_instr_q <= '0;
      out_data_q  <= '0;
    end else begin
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      out_instr_q <= out_instr_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    o_stall          = (state_q != S_IDLE);
    o_dmem_req_valid = (state_q == S_REQ);
    o_dmem_we        = (instr_q.decode.mem_op == MEM_STORE);
    o_dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    o_dmem_wdata     = wdata_q;
    o_dmem_wstrb     = wstrb_q;
    o_instr          = out_instr_q;
    o_data           = out_data_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed loads/stores/flushes push expected writeback entries,
// a negedge monitor pops and compares every valid o_instr.
module tb_mem_access;
  import mem_access_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  program_state_t ps;
  issued_instr_t  i_instr;
  reg_data_t      i_data;
  reg_data_t      i_store_data;
  logic           i_flush;
  logic           o_stall;
  issued_instr_t  o_instr;
  reg_data_t      o_data;
  logic           req_valid;
  logic           req_ready;
  logic           we;
  logic [31:0]    addr;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           resp_valid;
  logic [31:0]    rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    reg_data_t   data;
    logic        exc_valid;
    logic [3:0]  exc_code;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_ps             (ps),
    .i_instr          (i_instr),
    .i_data           (i_data),
    .i_store_data     (i_store_data),
    .i_flush          (i_flush),
    .o_stall          (o_stall),
    .o_instr          (o_instr),
    .o_data           (o_data),
    .o_dmem_req_valid (req_valid),
    .i_dmem_req_ready (req_ready),
    .o_dmem_we        (we),
    .o_dmem_addr      (addr),
    .o_dmem_wdata     (wdata),
    .o_dmem_wstrb     (wstrb),
    .i_dmem_resp_valid(resp_valid),
    .i_dmem_rdata     (rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid writeback must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_instr.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got pc 0x%0h data 0x%0h, expected no instruction",
                   o_instr.pc, o_data);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", 64'(o_instr.pc), 64'(e.pc));
          check("out_data", 64'(o_data), 64'(e.data));
          check("out_exc_valid", 64'(o_instr.except.valid), 64'(e.exc_valid));
          check("out_exc_code", 64'(o_instr.except.code), 64'(e.exc_code));
        end
      end
    end
  end

  function automatic issued_instr_t mk(input logic [31:0] pc, input mem_op_e op,
                                       input mem_size_e sz, input logic sgn);
    issued_instr_t t;
    t                   = '0;
    t.valid             = 1'b1;
    t.pc                = pc;
    t.rd                = 5'd3;
    t.decode.mem_op     = op;
    t.decode.mem_size   = sz;
    t.decode.mem_signed = sgn;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] pc, input reg_data_t d,
                            input logic ev, input logic [3:0] ec);
    exp_t e;
    e.pc = pc; e.data = d; e.exc_valid = ev; e.exc_code = ec;
    exp_q.push_back(e);
  endtask

  task automatic issue(input issued_instr_t ins, input reg_data_t d, input reg_data_t sd);
    i_instr      = ins;
    i_data       = d;
    i_store_data = sd;
    tick();
    i_instr      = '0;
    i_data       = '0;
    i_store_data = '0;
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] exp_addr,
                         input mem_size_e sz, input logic sgn, input logic [31:0] rd_word,
                         input int waits, input reg_data_t exp_data);
    expect_out(pc, exp_data, 1'b0, 4'd0);
    issue(mk(pc, MEM_LOAD, sz, sgn), a, '0);
    check("ld_req_valid", 64'(req_valid), 64'd1);
    check("ld_addr", 64'(addr), 64'(exp_addr));
    check("ld_we", 64'(we), 64'd0);
    check("ld_stall", 64'(o_stall), 64'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("ld_wait_stall", 64'(o_stall), 64'd1);
      tick();
    end
    resp_valid = 1'b1;
    rdata      = rd_word;
    tick();
    resp_valid = 1'b0;
    rdata      = '0;
    check("ld_out_valid", 64'(o_instr.valid), 64'd1);
    check("ld_stall_done", 64'(o_stall), 64'd0);
  endtask

  task automatic do_store(input logic [31:0] pc, input logic [31:0] a, input mem_size_e sz,
                          input logic [31:0] sd, input int ready_delay, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    expect_out(pc, a, 1'b0, 4'd0);
    issue(mk(pc, MEM_STORE, sz, 1'b0), a, sd);
    for (int i = 0; i <= ready_delay; i++) begin
      check("st_req_valid", 64'(req_valid), 64'd1);
      check("st_we", 64'(we), 64'd1);
      check("st_addr", 64'(addr), 64'(exp_addr));
      check("st_wdata", 64'(wdata), 64'(exp_wdata));
      check("st_wstrb", 64'(wstrb), 64'(exp_wstrb));
      check("st_stall", 64'(o_stall), 64'd1);
      if (i == ready_delay) req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
    end
    check("st_out_valid", 64'(o_instr.valid), 64'd1);
    check("st_req_dropped", 64'(req_valid), 64'd0);
    check("st_stall_done", 64'(o_stall), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    ps           = '0;
    i_instr      = '0;
    i_data       = '0;
    i_store_data = '0;
    i_flush      = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    rdata        = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_instr_valid", 64'(o_instr.valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);

    // ALU pass-through, then a bubble.
    expect_out(32'h100, 32'h1234, 1'b0, 4'd0);
    issue(mk(32'h100, MEM_NONE, MEM_W, 1'b0), 32'h1234, '0);
    check("alu_valid", 64'(o_instr.valid), 64'd1);
    check("alu_stall", 64'(o_stall), 64'd0);
    tick();
    check("alu_bubble", 64'(o_instr.valid), 64'd0);

    // Loads: lane extraction and extension.
    do_load(32'h104, 32'h1003, 32'h1000, MEM_B, 1'b1, 32'h80AABBCC, 0, 32'hFFFFFF80);
    do_load(32'h108, 32'h1003, 32'h1000, MEM_B, 1'b0, 32'h80AABBCC, 0, 32'h00000080);
    do_load(32'h10C, 32'h1001, 32'h1000, MEM_B, 1'b1, 32'h80AABBCC, 0, 32'hFFFFFFBB);
    do_load(32'h110, 32'h1002, 32'h1000, MEM_H, 1'b1, 32'h80AABBCC, 0, 32'hFFFF80AA);
    do_load(32'h114, 32'h1000, 32'h1000, MEM_H, 1'b0, 32'h12348765, 1, 32'h00008765);
    do_load(32'h118, 32'h1008, 32'h1008, MEM_W, 1'b0, 32'hCAFEF00D, 2, 32'hCAFEF00D);

    // Stores: replication and strobes, including a held-off ready.
    do_store(32'h120, 32'h2002, MEM_H, 32'hDEADBEEF, 3, 32'h2000, 32'hBEEFBEEF, 4'b1100);
    do_store(32'h124, 32'h2001, MEM_B, 32'h11223344, 0, 32'h2000, 32'h44444444, 4'b0010);
    do_store(32'h128, 32'h2004, MEM_W, 32'h01020304, 1, 32'h2004, 32'h01020304, 4'b1111);

    // Flush while waiting for load data: response two cycles later is dropped.
    issue(mk(32'h130, MEM_LOAD, MEM_W, 1'b0), 32'h4000, '0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    i_flush   = 1'b1;
    tick();
    i_flush = 1'b0;
    check("drain_stall", 64'(o_stall), 64'd1);
    tick();
    check("drain_stall_hold", 64'(o_stall), 64'd1);
    resp_valid = 1'b1;
    rdata      = 32'h55555555;
    tick();
    resp_valid = 1'b0;
    rdata      = '0;
    check("drain_done_stall", 64'(o_stall), 64'd0);
    check("drain_no_output", 64'(o_instr.valid), 64'd0);

    // Flush in IDLE drops the input.
    i_flush = 1'b1;
    issue(mk(32'h134, MEM_NONE, MEM_W, 1'b0), 32'h77, '0);
    i_flush = 1'b0;
    check("idle_flush_drop", 64'(o_instr.valid), 64'd0);

    // Flush in REQ without ready withdraws the request.
    issue(mk(32'h138, MEM_LOAD, MEM_W, 1'b0), 32'h5000, '0);
    check("req_before_flush", 64'(req_valid), 64'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("req_withdrawn", 64'(req_valid), 64'd0);
    check("req_flush_stall", 64'(o_stall), 64'd0);
    tick();

    // Misaligned accesses.
`ifdef MEM_MISALIGN_EXCEPT_EN
    expect_out(32'h140, 32'h3001, 1'b1, EXCEPT_MISALIGN_LOAD);
    issue(mk(32'h140, MEM_LOAD, MEM_W, 1'b0), 32'h3001, '0);
    check("mis_ld_no_req", 64'(req_valid), 64'd0);
    check("mis_ld_stall", 64'(o_stall), 64'd0);
    check("mis_ld_valid", 64'(o_instr.valid), 64'd1);
    expect_out(32'h144, 32'h3003, 1'b1, EXCEPT_MISALIGN_STORE);
    issue(mk(32'h144, MEM_STORE, MEM_H, 1'b0), 32'h3003, 32'h1234);
    check("mis_st_no_req", 64'(req_valid), 64'd0);
    check("mis_st_valid", 64'(o_instr.valid), 64'd1);
`else
    do_load(32'h140, 32'h3001, 32'h3000, MEM_W, 1'b0, 32'h11223344, 0, 32'h11223344);
    do_store(32'h144, 32'h3003, MEM_H, 32'h00001234, 0, 32'h3000, 32'h12341234, 4'b1100);
`endif

    // Reset while a store request is pending.
    issue(mk(32'h150, MEM_STORE, MEM_W, 1'b0), 32'h6000, 32'hA5A5A5A5);
    check("prerst_req_valid", 64'(req_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_stall", 64'(o_stall), 64'd0);
    check("rst2_req_valid", 64'(req_valid), 64'd0);
    check("rst2_we", 64'(we), 64'd0);
    check("rst2_addr", 64'(addr), 64'd0);
    check("rst2_wdata", 64'(wdata), 64'd0);
    check("rst2_wstrb", 64'(wstrb), 64'd0);
    check("rst2_instr", 64'(o_instr), 64'd0);
    check("rst2_data", 64'(o_data), 64'd0);

    // Normal operation resumes after reset.
    expect_out(32'h160, 32'h9ABC, 1'b0, 4'd0);
    issue(mk(32'h160, MEM_NONE, MEM_W, 1'b0), 32'h9ABC, '0);
    check("post_rst_valid", 64'(o_instr.valid), 64'd1);

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
